// File: rtl/disp_arbiter.sv
// disp_arbiter: fixed-priority owner selection for the shared 4-digit display.
// Priority ERROR > RESULT > ENTRY, with a minimum hold time for RESULT/ERROR.
// Optional error blink is compiled in with `define DISP_ARBITER_ERR_BLINK_EN.
module disp_arbiter #(
  parameter logic [23:0] HOLD_CYCLES  = 24'd10_000_000,
  parameter logic [23:0] BLINK_CYCLES = 24'd5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ent_valid,
  input  logic [15:0] ent_data,
  input  logic        res_valid,
  input  logic [15:0] res_data,
  input  logic        err_valid,
  input  logic [15:0] err_data,
  output logic        ent_ack,
  output logic        res_ack,
  output logic        err_ack,
  input  logic        clear,
  output logic [15:0] displayed_number,
  output logic        display_sel,
  output logic        dp,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    RESULT = 2'd2,
    ERROR  = 2'd3
  } state_t;

  // A zero hold is treated as "no hold" rather than wrapping the counter.
  localparam logic [23:0] HOLD_LOAD = (HOLD_CYCLES == 24'd0) ? 24'd0 : 24'(HOLD_CYCLES - 24'd1);

  state_t      state, state_n;
  logic [23:0] hold_cnt, hold_n;
  logic [15:0] disp_n;
  logic        ent_ack_n, res_ack_n, err_ack_n;
  logic        res_ok, ent_ok;
  logic        win_err, win_res, win_ent;

`ifdef DISP_ARBITER_ERR_BLINK_EN
  localparam logic [23:0] BLINK_LAST = (BLINK_CYCLES == 24'd0) ? 24'd0 : 24'(BLINK_CYCLES - 24'd1);

  logic [15:0] err_code, err_code_n;
  logic [23:0] blink_cnt, blink_cnt_n;
  logic        blink_ph, blink_ph_n;
`endif

  assign owner = state;

  // Winner selection: error always eligible; lower priority needs expired hold.
  always_comb begin
    res_ok  = (state != ERROR) || (hold_cnt == 24'd0);
    ent_ok  = (state == IDLE) || (state == ENTRY) || (hold_cnt == 24'd0);
    win_err = err_valid;
    win_res = res_valid && res_ok && !win_err;
    win_ent = ent_valid && ent_ok && !win_err && !win_res;
  end

  // Next-state, hold counter, capture and ack generation.
  always_comb begin
    state_n   = state;
    hold_n    = (hold_cnt == 24'd0) ? 24'd0 : 24'(hold_cnt - 24'd1);
    disp_n    = displayed_number;
    ent_ack_n = 1'b0;
    res_ack_n = 1'b0;
    err_ack_n = 1'b0;
`ifdef DISP_ARBITER_ERR_BLINK_EN
    err_code_n  = err_code;
    blink_cnt_n = 24'd0;
    blink_ph_n  = 1'b0;
    if (state == ERROR) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_ph_n = ~blink_ph;
        disp_n     = blink_ph_n ? 16'hEEEE : err_code;
      end else begin
        blink_cnt_n = 24'(blink_cnt + 24'd1);
        blink_ph_n  = blink_ph;
      end
    end
`endif
    if (clear) begin
      state_n = IDLE;
      hold_n  = 24'd0;
      disp_n  = 16'h0000;
`ifdef DISP_ARBITER_ERR_BLINK_EN
      blink_cnt_n = 24'd0;
      blink_ph_n  = 1'b0;
`endif
    end else if (win_err) begin
      state_n   = ERROR;
      hold_n    = HOLD_LOAD;
      disp_n    = err_data;
      err_ack_n = 1'b1;
`ifdef DISP_ARBITER_ERR_BLINK_EN
      err_code_n  = err_data;
      blink_cnt_n = 24'd0;
      blink_ph_n  = 1'b0;
`endif
    end else if (win_res) begin
      state_n   = RESULT;
      hold_n    = HOLD_LOAD;
      disp_n    = res_data;
      res_ack_n = 1'b1;
`ifdef DISP_ARBITER_ERR_BLINK_EN
      blink_cnt_n = 24'd0;
      blink_ph_n  = 1'b0;
`endif
    end else if (win_ent) begin
      state_n   = ENTRY;
      hold_n    = 24'd0;
      disp_n    = ent_data;
      ent_ack_n = 1'b1;
`ifdef DISP_ARBITER_ERR_BLINK_EN
      blink_cnt_n = 24'd0;
      blink_ph_n  = 1'b0;
`endif
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      hold_cnt         <= 24'd0;
      displayed_number <= 16'h0000;
      display_sel      <= 1'b0;
      dp               <= 1'b0;
      ent_ack          <= 1'b0;
      res_ack          <= 1'b0;
      err_ack          <= 1'b0;
    end else begin
      state            <= state_n;
      hold_cnt         <= hold_n;
      displayed_number <= disp_n;
      display_sel      <= (state_n != IDLE);
      dp               <= (state_n == RESULT);
      ent_ack          <= ent_ack_n;
      res_ack          <= res_ack_n;
      err_ack          <= err_ack_n;
    end
  end

`ifdef DISP_ARBITER_ERR_BLINK_EN
  // Blink phase counter and captured error code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_code  <= 16'h0000;
      blink_cnt <= 24'd0;
      blink_ph  <= 1'b0;
    end else begin
      err_code  <= err_code_n;
      blink_cnt <= blink_cnt_n;
      blink_ph  <= blink_ph_n;
    end
  end
`endif

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed self-checking bench for disp_arbiter (HOLD_CYCLES=16, BLINK_CYCLES=4).
module tb_disp_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ent_valid, res_valid, err_valid, clear;
  logic [15:0] ent_data, res_data, err_data;
  logic        ent_ack, res_ack, err_ack;
  logic [15:0] displayed_number;
  logic        display_sel, dp;
  logic [1:0]  owner;

  int n_cmp = 0;
  int n_bad = 0;

  disp_arbiter #(.HOLD_CYCLES(24'd16), .BLINK_CYCLES(24'd4)) dut (
    .clk(clk), .reset(reset),
    .ent_valid(ent_valid), .ent_data(ent_data),
    .res_valid(res_valid), .res_data(res_data),
    .err_valid(err_valid), .err_data(err_data),
    .ent_ack(ent_ack), .res_ack(res_ack), .err_ack(err_ack),
    .clear(clear),
    .displayed_number(displayed_number),
    .display_sel(display_sel), .dp(dp), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ent_valid = 0; res_valid = 0; err_valid = 0; clear = 0;
    ent_data = '0; res_data = '0; err_data = '0;
    step(); step();
    n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL reset_owner: got %0d want 0", owner); end
    n_cmp++; if (displayed_number !== 16'h0000) begin n_bad++; $display("FAIL reset_disp: got %h want 0000", displayed_number); end
    n_cmp++; if ({display_sel, dp} !== 2'b00) begin n_bad++; $display("FAIL reset_sel_dp: got %b want 00", {display_sel, dp}); end
    n_cmp++; if ({ent_ack, res_ack, err_ack} !== 3'b000) begin n_bad++; $display("FAIL reset_acks: got %b want 000", {ent_ack, res_ack, err_ack}); end
    reset = 1'b1;
    step();
    n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL post_reset_owner: got %0d want 0", owner); end
  endtask

  task automatic test_entry();
    ent_valid = 1; ent_data = 16'h0012;
    step();
    n_cmp++; if (ent_ack !== 1'b1) begin n_bad++; $display("FAIL ent_ack: got %b want 1", ent_ack); end
    n_cmp++; if (displayed_number !== 16'h0012) begin n_bad++; $display("FAIL ent_disp: got %h want 0012", displayed_number); end
    n_cmp++; if (owner !== 2'd1) begin n_bad++; $display("FAIL ent_owner: got %0d want 1", owner); end
    n_cmp++; if ({display_sel, dp} !== 2'b10) begin n_bad++; $display("FAIL ent_sel_dp: got %b want 10", {display_sel, dp}); end
    ent_valid = 0;
    step();
    n_cmp++; if (ent_ack !== 1'b0) begin n_bad++; $display("FAIL ent_ack_pulse: got %b want 0", ent_ack); end
  endtask

  task automatic test_preempt_hold();
    int cnt;
    res_valid = 1; res_data = 16'h0042;
    step();
    n_cmp++; if (res_ack !== 1'b1) begin n_bad++; $display("FAIL res_ack: got %b want 1", res_ack); end
    n_cmp++; if (owner !== 2'd2) begin n_bad++; $display("FAIL res_owner: got %0d want 2", owner); end
    n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL res_dp: got %b want 1", dp); end
    n_cmp++; if (displayed_number !== 16'h0042) begin n_bad++; $display("FAIL res_disp: got %h want 0042", displayed_number); end
    res_valid = 0;
    for (int i = 0; i < 5; i++) step();
    // Hold is 10 here; ent must wait 10 more edges, accepted on the 11th.
    ent_valid = 1; ent_data = 16'h0034;
    cnt = 0;
    while (cnt < 30) begin
      step();
      cnt++;
      if (ent_ack) break;
    end
    ent_valid = 0;
    n_cmp++; if (cnt !== 11) begin n_bad++; $display("FAIL ent_hold_wait: got %0d edges want 11", cnt); end
    n_cmp++; if (owner !== 2'd1) begin n_bad++; $display("FAIL ent_after_hold_owner: got %0d want 1", owner); end
    n_cmp++; if (displayed_number !== 16'h0034) begin n_bad++; $display("FAIL ent_after_hold_disp: got %h want 0034", displayed_number); end
    n_cmp++; if (dp !== 1'b0) begin n_bad++; $display("FAIL ent_after_hold_dp: got %b want 0", dp); end
  endtask

  task automatic test_simultaneous();
    int cnt;
    clear = 1;
    step();
    clear = 0;
    n_cmp++; if (owner !== 2'd0 || displayed_number !== 16'h0000) begin n_bad++; $display("FAIL clear_idle: got owner %0d disp %h want 0 0000", owner, displayed_number); end
    err_valid = 1; err_data = 16'h0E05;
    res_valid = 1; res_data = 16'h0077;
    ent_valid = 1; ent_data = 16'h0011;
    step();
    err_valid = 0; ent_valid = 0;
    n_cmp++; if ({ent_ack, res_ack, err_ack} !== 3'b001) begin n_bad++; $display("FAIL simul_acks: got %b want 001", {ent_ack, res_ack, err_ack}); end
    n_cmp++; if (displayed_number !== 16'h0E05) begin n_bad++; $display("FAIL simul_disp: got %h want 0E05", displayed_number); end
    n_cmp++; if (owner !== 2'd3) begin n_bad++; $display("FAIL simul_owner: got %0d want 3", owner); end
    cnt = 0;
    while (cnt < 40) begin
      step();
      cnt++;
      if (res_ack) break;
    end
    res_valid = 0;
    n_cmp++; if (cnt !== 16) begin n_bad++; $display("FAIL res_after_err_wait: got %0d edges want 16", cnt); end
    n_cmp++; if (owner !== 2'd2 || displayed_number !== 16'h0077) begin n_bad++; $display("FAIL res_after_err: got owner %0d disp %h want 2 0077", owner, displayed_number); end
  endtask

  task automatic test_clear_vs_err();
    clear = 1;
    err_valid = 1; err_data = 16'h0E07;
    step();
    clear = 0;
    n_cmp++; if (err_ack !== 1'b0) begin n_bad++; $display("FAIL clear_err_ack: got %b want 0", err_ack); end
    n_cmp++; if (owner !== 2'd0 || displayed_number !== 16'h0000 || display_sel !== 1'b0) begin n_bad++; $display("FAIL clear_err_state: got owner %0d disp %h sel %b want 0 0000 0", owner, displayed_number, display_sel); end
    step();
    err_valid = 0;
    n_cmp++; if (err_ack !== 1'b1 || owner !== 2'd3 || displayed_number !== 16'h0E07) begin n_bad++; $display("FAIL err_after_clear: got ack %b owner %0d disp %h want 1 3 0E07", err_ack, owner, displayed_number); end
  endtask

  task automatic test_reset_mid_result();
    clear = 1;
    step();
    clear = 0;
    res_valid = 1; res_data = 16'h0055;
    step();
    res_valid = 0;
    n_cmp++; if (res_ack !== 1'b1 || owner !== 2'd2) begin n_bad++; $display("FAIL res_before_reset: got ack %b owner %0d want 1 2", res_ack, owner); end
    for (int i = 0; i < 8; i++) step();
    // hold_cnt is 7 now; a pending entry offer must be dropped by reset.
    ent_valid = 1; ent_data = 16'h0099;
    reset = 1'b0;
    #1;
    n_cmp++; if (owner !== 2'd0 || displayed_number !== 16'h0000 || dp !== 1'b0 || display_sel !== 1'b0) begin n_bad++; $display("FAIL async_reset: got owner %0d disp %h dp %b sel %b want 0 0000 0 0", owner, displayed_number, dp, display_sel); end
    n_cmp++; if ({ent_ack, res_ack, err_ack} !== 3'b000) begin n_bad++; $display("FAIL async_reset_acks: got %b want 000", {ent_ack, res_ack, err_ack}); end
    ent_valid = 0;
    step();
    reset = 1'b1;
    step();
    n_cmp++; if (owner !== 2'd0 || ent_ack !== 1'b0) begin n_bad++; $display("FAIL after_reset_idle: got owner %0d ent_ack %b want 0 0", owner, ent_ack); end
  endtask

  task automatic test_blink();
    logic [15:0] exp;
    err_valid = 1; err_data = 16'h00E1;
    step();
    err_valid = 0;
    n_cmp++; if (err_ack !== 1'b1 || displayed_number !== 16'h00E1) begin n_bad++; $display("FAIL blink_entry: got ack %b disp %h want 1 00E1", err_ack, displayed_number); end
    for (int k = 1; k < 12; k++) begin
      step();
`ifdef DISP_ARBITER_ERR_BLINK_EN
      exp = (((k / 4) % 2) == 1) ? 16'hEEEE : 16'h00E1;
`else
      exp = 16'h00E1;
`endif
      n_cmp++; if (displayed_number !== exp || owner !== 2'd3) begin n_bad++; $display("FAIL blink_k%0d: got disp %h owner %0d want %h 3", k, displayed_number, owner, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_preempt_hold();
    test_simultaneous();
    test_clear_vs_err();
    test_reset_mid_result();
    test_blink();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
